snoop_pingpong_mem: RTL and testbench

Two-bank (ping-pong) packet memory that sits directly downstream of the AXI Stream snooper: it absorbs the snooper's `wr_addr`/`wr_data`/`wr_en`/`done` write stream and drives its `mem_ready`. It hands each completed packet to the filter core's read port. While the filter reads one bank, the snooper fills the other, so back-to-back packets are captured without a stall unless both banks are occupied.

---
 rtl/snoop_pingpong_mem.sv | 130 +++++++++++++
 tb/tb_snoop_pingpong_mem.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/snoop_pingpong_mem.sv
// Two-bank ping-pong packet buffer between the stream snooper (writer) and the filter core (reader).
// Optional macro SNOOP_PINGPONG_RDREG_EN adds a second read-data register stage (read latency 2).
module snoop_pingpong_mem #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  done,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  pkt_avail,
    output logic [ADDR_WIDTH:0]   pkt_len,
    input  logic                  rd_release
);

    typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_state_t;

    bank_state_t           state_q [2];
    bank_state_t           state_d [2];
    logic [ADDR_WIDTH:0]   len_q [2];
    logic [ADDR_WIDTH:0]   len_d [2];
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic [DATA_WIDTH-1:0] mem [2][2**ADDR_WIDTH];

    logic wr_acc;
    logic rd_acc;
    logic rel_acc;

    assign mem_ready = (state_q[wr_sel_q] != FULL);
    assign pkt_avail = (state_q[rd_sel_q] == FULL);
    assign pkt_len   = len_q[rd_sel_q];
    assign wr_acc    = wr_en && mem_ready;
    assign rd_acc    = rd_en && pkt_avail;
    assign rel_acc   = rd_release && pkt_avail;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

    // A write bank is never FULL and a releasable bank always is, so the two updates never collide.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (wr_acc) begin
            if (done) begin
                state_d[wr_sel_q] = FULL;
                len_d[wr_sel_q]   = {1'b0, wr_addr} + {{ADDR_WIDTH{1'b0}}, 1'b1};
                wr_sel_d          = ~wr_sel_q;
            end else begin
                state_d[wr_sel_q] = FILLING;
            end
        end
        if (rel_acc) begin
            state_d[rd_sel_q] = EMPTY;
            rd_sel_d          = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= '{EMPTY, EMPTY};
            len_q    <= '{'0, '0};
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_sel_q][wr_addr] <= wr_data;
        end
    end

`ifdef SNOOP_PINGPONG_RDREG_EN
    // RAM-side read register (no reset) feeding a reset output register.
    logic [DATA_WIDTH-1:0] rd_pre_q;
    logic                  rd_pre_vld_q;

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            rd_pre_q <= mem[rd_sel_q][rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pre_vld_q <= 1'b0;
        end else begin
            rd_pre_vld_q <= rd_acc;
        end
    end

    always_comb begin
        rd_valid_d = rd_pre_vld_q;
        rd_data_d  = rd_pre_vld_q ? rd_pre_q : rd_data_q;
    end
`else
    always_comb begin
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? mem[rd_sel_q][rd_addr] : rd_data_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_snoop_pingpong_mem.sv
// Directed bench for snoop_pingpong_mem: fill/drain, back-pressure, length edges, overlap, reset.
module tb_snoop_pingpong_mem;

    localparam int DW = 64;
    localparam int AW = 9;
`ifdef SNOOP_PINGPONG_RDREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          done = 1'b0;
    logic          mem_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          pkt_avail;
    logic [AW:0]   pkt_len;
    logic          rd_release = 1'b0;

    int checks = 0;
    int errors = 0;

    snoop_pingpong_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .done(done),
        .mem_ready(mem_ready),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .pkt_avail(pkt_avail), .pkt_len(pkt_len), .rd_release(rd_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dn, input logic rel);
        wr_en = 1'b1; wr_addr = a; wr_data = d; done = dn; rd_release = rel;
        @(posedge clk); #1;
        wr_en = 1'b0; done = 1'b0; rd_release = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic rel, input logic [DW-1:0] exp, input string tag);
        rd_en = 1'b1; rd_addr = a; rd_release = rel;
        @(posedge clk); #1;
        rd_en = 1'b0; rd_release = 1'b0;
        repeat (LAT-1) begin @(posedge clk); #1; end
        chk({tag, "_vld"}, DW'(rd_valid), DW'(1));
        chk(tag, rd_data, exp);
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        @(posedge clk); #1;
        rd_release = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_ready", DW'(mem_ready), DW'(1));
        chk("rst_avail", DW'(pkt_avail), DW'(0));
        chk("rst_len",   DW'(pkt_len),   DW'(0));
        chk("rst_vld",   DW'(rd_valid),  DW'(0));
        chk("rst_data",  rd_data,        DW'(0));
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // 4-word packet into bank 0
        for (int i = 0; i < 4; i++) wr(AW'(i), DW'(8'h11 * (i + 1)), (i == 3), 1'b0);
        chk("p4_avail", DW'(pkt_avail), DW'(1));
        chk("p4_len",   DW'(pkt_len),   DW'(4));
        chk("p4_ready", DW'(mem_ready), DW'(1));
        for (int i = 0; i < 4; i++) rd(AW'(i), 1'b0, DW'(8'h11 * (i + 1)), "p4_rd");
        @(posedge clk); #1;
        chk("p4_vld_drop", DW'(rd_valid), DW'(0));
        release_bank();
        chk("p4_rel_avail", DW'(pkt_avail), DW'(0));

        // two 8-word packets: A into bank 1, B into bank 0, then writer blocked
        for (int i = 0; i < 8; i++) wr(AW'(i), DW'(12'h100 + i), (i == 7), 1'b0);
        for (int i = 0; i < 8; i++) wr(AW'(i), DW'(12'h200 + i), (i == 7), 1'b0);
        chk("bp_ready", DW'(mem_ready), DW'(0));
        chk("bp_avail", DW'(pkt_avail), DW'(1));
        wr(AW'(0), DW'(16'hDEAD), 1'b1, 1'b0);
        chk("bp_drop_ready", DW'(mem_ready), DW'(0));
        chk("bp_drop_len",   DW'(pkt_len),   DW'(8));
        rd(AW'(0), 1'b0, DW'(12'h100), "bp_a0");
        release_bank();
        chk("bp_rel_ready", DW'(mem_ready), DW'(1));
        chk("bp_b_avail",   DW'(pkt_avail), DW'(1));
        chk("bp_b_len",     DW'(pkt_len),   DW'(8));
        rd(AW'(0), 1'b0, DW'(12'h200), "bp_b0");
        rd(AW'(7), 1'b0, DW'(12'h207), "bp_b7");
        release_bank();
        chk("bp_empty", DW'(pkt_avail), DW'(0));

        // 1-word packet into bank 1
        wr(AW'(0), DW'(8'h55), 1'b1, 1'b0);
        chk("one_avail", DW'(pkt_avail), DW'(1));
        chk("one_len",   DW'(pkt_len),   DW'(1));
        rd(AW'(0), 1'b0, DW'(8'h55), "one_rd");
        release_bank();

        // full-bank packet into bank 0
        for (int i = 0; i < 2**AW; i++) wr(AW'(i), DW'(i), (i == 2**AW - 1), 1'b0);
        chk("full_len", DW'(pkt_len), DW'(2**AW));
        rd(AW'(2**AW - 1), 1'b0, DW'(2**AW - 1), "full_rd");

        // done on bank 1 coincides with release of bank 0
        wr(AW'(0), DW'(12'h300), 1'b0, 1'b0);
        wr(AW'(1), DW'(12'h301), 1'b0, 1'b0);
        wr(AW'(2), DW'(12'h302), 1'b1, 1'b1);
        chk("ovl_avail", DW'(pkt_avail), DW'(1));
        chk("ovl_len",   DW'(pkt_len),   DW'(3));
        chk("ovl_ready", DW'(mem_ready), DW'(1));
        rd(AW'(1), 1'b0, DW'(12'h301), "ovl_rd");
        rd(AW'(0), 1'b1, DW'(12'h300), "rdrel_rd");
        chk("rdrel_avail", DW'(pkt_avail), DW'(0));

        // read and release with nothing available
        rd_en = 1'b1; rd_release = 1'b1; rd_addr = '0;
        @(posedge clk); #1;
        rd_en = 1'b0; rd_release = 1'b0;
        repeat (LAT) begin @(posedge clk); #1; end
        chk("idle_vld", DW'(rd_valid), DW'(0));
        wr(AW'(0), DW'(8'h77), 1'b1, 1'b0);
        chk("idle_ptr_avail", DW'(pkt_avail), DW'(1));
        rd(AW'(0), 1'b0, DW'(8'h77), "idle_rd");
        release_bank();

        // reset mid-packet on bank 1
        for (int i = 0; i < 3; i++) wr(AW'(i), DW'(8'h90 + i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", DW'(mem_ready), DW'(1));
        chk("mrst_avail", DW'(pkt_avail), DW'(0));
        chk("mrst_len",   DW'(pkt_len),   DW'(0));
        chk("mrst_vld",   DW'(rd_valid),  DW'(0));
        chk("mrst_data",  rd_data,        DW'(0));
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) wr(AW'(i), DW'(8'hA0 + i), (i == 3), 1'b0);
        chk("post_avail", DW'(pkt_avail), DW'(1));
        chk("post_len",   DW'(pkt_len),   DW'(4));
        rd(AW'(0), 1'b0, DW'(8'hA0), "post_rd0");
        rd(AW'(3), 1'b0, DW'(8'hA3), "post_rd3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
